fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined ARM64 core and the reading end of the instruction ROM. It owns the program counter, drives the ROM word address, and captures the returned instruction into the IF/ID pipeline register. It also handles stall, branch redirect/flush, out-of-range fault and halt detection. Decode consumes its outputs; branch and hazard logic drive its control inputs.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/if_id_reg.sv | 24 ++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Bubble/halt encodings and the IF/ID bundle.
package fetch_pkg;

  localparam int XLEN        = 64;
  localparam int ILEN        = 32;
  localparam int FETCH_BYTES = 4;

  localparam logic [ILEN-1:0] NOP_INSTR  = 32'h8b1f03ff;
  localparam logic [ILEN-1:0] HALT_INSTR = 32'hb400001f;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    pc:    '0,
    instr: NOP_INSTR,
    valid: 1'b0
  };

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats enable.
// Ports: clk, rst_n, en, flush, d (if_id_t), q (if_id_t).
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= IF_ID_BUBBLE;
    end else if (flush) begin
      q <= IF_ID_BUBBLE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, ROM address, IF/ID capture.
// Ports: clk, reset_n, imem_addr/imem_q (ROM), stall_f,
// redirect/redirect_target, if_pc/if_instr/if_valid,
// halted, fetch_fault.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int N  = 64,
  parameter int IW = 32,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_q,
  input  logic          stall_f,
  input  logic          redirect,
  input  logic [N-1:0]  redirect_target,
  output logic [N-1:0]  if_pc,
  output logic [IW-1:0] if_instr,
  output logic          if_valid,
  output logic          halted,
  output logic          fetch_fault
);

  logic [N-1:0] pc_f;
  logic [N-1:0] pc_n;
  logic         halted_n;
  logic         fault_n;
  logic         illegal;
  logic         frozen;
  logic         en;
  logic         flush;
  if_id_t       d;
  if_id_t       q;

  logic sel_frz;
  logic sel_rd;
  logic sel_st;
  logic sel_il;
  logic sel_run;

  assign imem_addr = pc_f[AW+1:2];

  assign illegal = (|pc_f[N-1:AW+2]) | (|pc_f[1:0]);
  assign frozen  = halted | fetch_fault;

  // One-hot priority: frozen > redirect > stall > fault > run.
  assign sel_frz = frozen;
  assign sel_rd  = !frozen && redirect;
  assign sel_st  = !frozen && !redirect && stall_f;
  assign sel_il  = !frozen && !redirect && !stall_f
                   && illegal;
  assign sel_run = !frozen && !redirect && !stall_f
                   && !illegal;

  always_comb begin
    pc_n     = pc_f;
    halted_n = halted;
    fault_n  = fetch_fault;
    en       = 1'b0;
    flush    = 1'b0;
    d.pc     = pc_f;
    d.instr  = imem_q;
    d.valid  = 1'b1;
    unique case (1'b1)
      sel_frz: begin
        flush = 1'b1;
      end
      sel_rd: begin
        pc_n  = redirect_target;
        flush = 1'b1;
      end
      sel_st: begin
      end
      sel_il: begin
        fault_n = 1'b1;
        flush   = 1'b1;
      end
      sel_run: begin
        en   = 1'b1;
        pc_n = pc_f + N'(FETCH_BYTES);
        if (imem_q == HALT_INSTR)
          halted_n = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_f        <= '0;
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      pc_f        <= pc_n;
      halted      <= halted_n;
      fetch_fault <= fault_n;
    end
  end

  if_id_reg u_if_id (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (en),
    .flush (flush),
    .d     (d),
    .q     (q)
  );

  assign if_pc    = q.pc;
  assign if_instr = q.instr;
  assign if_valid = q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit.
// Directed steps push expectations; monitor checks.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h8b1f03ff;
  localparam logic [31:0] HALT = 32'hb400001f;

  logic        clk;
  logic        reset_n;
  logic [6:0]  imem_addr;
  logic [31:0] imem_q;
  logic        stall_f;
  logic        redirect;
  logic [63:0] redirect_target;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;
  logic        fetch_fault;

  logic [31:0] rom [128];

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        hlt;
    logic        flt;
    logic [6:0]  addr;
  } exp_t;

  exp_t q_exp[$];
  int   n_chk;
  int   n_fail;

  fetch_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_addr       (imem_addr),
    .imem_q          (imem_q),
    .stall_f         (stall_f),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_valid        (if_valid),
    .halted          (halted),
    .fetch_fault     (fetch_fault)
  );

  assign imem_q = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input exp_t e);
    n_chk++;
    if (if_pc !== e.pc || if_instr !== e.instr ||
        if_valid !== e.valid || halted !== e.hlt ||
        fetch_fault !== e.flt || imem_addr !== e.addr) begin
      n_fail++;
      $display("FAIL %s: got pc=%h ins=%h v=%b h=%b f=%b a=%0d want pc=%h ins=%h v=%b h=%b f=%b a=%0d",
               nm, if_pc, if_instr, if_valid, halted,
               fetch_fault, imem_addr, e.pc, e.instr,
               e.valid, e.hlt, e.flt, e.addr);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q_exp.size() > 0) begin
      exp_t e;
      e = q_exp.pop_front();
      check("edge", e);
    end
  end

  task automatic step(input logic st, input logic rd,
                      input logic [63:0] tgt,
                      input logic [63:0] pc,
                      input logic [31:0] ins,
                      input logic v, input logic h,
                      input logic f, input logic [6:0] a);
    exp_t e;
    stall_f         = st;
    redirect        = rd;
    redirect_target = tgt;
    e.pc    = pc;
    e.instr = ins;
    e.valid = v;
    e.hlt   = h;
    e.flt   = f;
    e.addr  = a;
    q_exp.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset;
    exp_t e;
    e.pc    = 64'h0;
    e.instr = NOP;
    e.valid = 1'b0;
    e.hlt   = 1'b0;
    e.flt   = 1'b0;
    e.addr  = 7'd0;
    reset_n = 1'b0;
    #1;
    check("async_reset", e);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 128; i++)
      rom[i] = 32'he000_0000 + 32'(i);
    rom[0]  = 32'hf8000001;
    rom[1]  = 32'hf8008002;
    rom[85] = HALT;
    stall_f         = 1'b0;
    redirect        = 1'b0;
    redirect_target = '0;
    reset_n         = 1'b1;
    @(posedge clk);
    #2;
    async_reset();

    // free run
    step(0, 0, 0, 64'h0, 32'hf8000001, 1, 0, 0, 7'd1);
    step(0, 0, 0, 64'h4, 32'hf8008002, 1, 0, 0, 7'd2);
    // stall two cycles at pc 8
    step(1, 0, 0, 64'h4, 32'hf8008002, 1, 0, 0, 7'd2);
    step(1, 0, 0, 64'h4, 32'hf8008002, 1, 0, 0, 7'd2);
    step(0, 0, 0, 64'h8, 32'he0000002, 1, 0, 0, 7'd3);
    // redirect beats stall
    step(1, 1, 64'h10, 64'h0, NOP, 0, 0, 0, 7'd4);
    step(0, 0, 0, 64'h10, 32'he0000004, 1, 0, 0, 7'd5);
    step(0, 0, 0, 64'h14, 32'he0000005, 1, 0, 0, 7'd6);
    // out of range target
    step(0, 1, 64'h200, 64'h0, NOP, 0, 0, 0, 7'd0);
    step(0, 0, 0, 64'h0, NOP, 0, 0, 1, 7'd0);
    step(0, 1, 64'h0, 64'h0, NOP, 0, 0, 1, 7'd0);
    step(0, 0, 0, 64'h0, NOP, 0, 0, 1, 7'd0);
    // reset between edges clears the fault
    async_reset();
    step(0, 0, 0, 64'h0, 32'hf8000001, 1, 0, 0, 7'd1);
    // halt at 0x154
    step(0, 1, 64'h154, 64'h0, NOP, 0, 0, 0, 7'd85);
    step(0, 0, 0, 64'h154, HALT, 1, 1, 0, 7'd86);
    step(0, 1, 64'h0, 64'h0, NOP, 0, 1, 0, 7'd86);
    step(1, 0, 0, 64'h0, NOP, 0, 1, 0, 7'd86);
    step(0, 0, 0, 64'h0, NOP, 0, 1, 0, 7'd86);
    // misaligned target faults on the following edge
    async_reset();
    step(0, 1, 64'h6, 64'h0, NOP, 0, 0, 0, 7'd1);
    step(0, 0, 0, 64'h0, NOP, 0, 0, 1, 7'd1);
    step(0, 0, 0, 64'h0, NOP, 0, 0, 1, 7'd1);

    repeat (2) @(posedge clk);
    #2;
    n_chk++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0",
               q_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
